pc_sequencer: RTL and testbench

- Program-counter stage of the single-cycle RV32I core; sits directly downstream of the branch-decision gate (branch & zero).
- Consumes the taken-branch signal, jump controls and immediate; produces the PC driving instruction memory.
- Holds the PC register, selects the next PC and detects misaligned control-flow targets (redirects to a trap vector).
- Supports stall and a terminal halt.

---
 rtl/pc_pkg.sv | 28 ++
 rtl/pc_next_mux.sv | 30 +++
 rtl/pc_sequencer.sv | 109 ++++++++++
 tb/tb_pc_sequencer.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types for the PC stage: FSM states, next-PC selects, widths.
// Used by pc_next_mux and pc_sequencer.
package pc_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2,
    HALT = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SEQ  = 2'd0,
    BR   = 2'd1,
    JAL  = 2'd2,
    JALR = 2'd3
  } sel_e;

  function automatic logic is_misaligned(
    input logic [XLEN-1:0] addr
  );
    return |addr[1:0];
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC target computation and alignment check (combinational).
// Sequential flow is never flagged as misaligned.
module pc_next_mux
  import pc_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_val,
  input  sel_e            sel,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);

  logic [XLEN-1:0] jalr_sum;

  assign jalr_sum = rs1_val + imm;

  always_comb begin
    target = pc + XLEN'(INSTR_BYTES);
    unique case (sel)
      SEQ:     target = pc + XLEN'(INSTR_BYTES);
      BR, JAL: target = pc + imm;
      JALR:    target = {jalr_sum[XLEN-1:1], 1'b0};
      default: target = pc + XLEN'(INSTR_BYTES);
    endcase
  end

  assign misaligned = (sel != SEQ) && is_misaligned(target);

endmodule

// File: rtl/pc_sequencer.sv
// PC register, next-PC FSM (BOOT/RUN/TRAP/HALT) and misaligned trap.
// Define PC_PERF_CNT_EN to add taken_cnt/retire_cnt counters.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_src,
  input  logic        jump,
  input  logic        jalr,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_val,
  input  logic        stall,
  input  logic        halt,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        trap,
  output logic [31:0] bad_target
`ifdef PC_PERF_CNT_EN
  ,
  output logic [31:0] taken_cnt,
  output logic [31:0] retire_cnt
`endif
);

  state_e      state, state_n;
  sel_e        sel;
  logic [31:0] pc_n, bad_n, target;
  logic        mis, retire_en, taken_en;

  always_comb begin
    sel = SEQ;
    if (jalr)        sel = JALR;
    else if (jump)   sel = JAL;
    else if (pc_src) sel = BR;
  end

  pc_next_mux u_mux (
    .pc         (pc),
    .imm        (imm),
    .rs1_val    (rs1_val),
    .sel        (sel),
    .target     (target),
    .misaligned (mis)
  );

  always_comb begin
    state_n = state;
    pc_n    = pc;
    bad_n   = bad_target;
    unique case (state)
      BOOT: state_n = RUN;
      RUN: begin
        if (halt) begin
          state_n = HALT;
        end else if (!stall) begin
          if (mis) begin
            pc_n    = TRAP_VEC;
            bad_n   = target;
            state_n = TRAP;
          end else begin
            pc_n = target;
          end
        end
      end
      TRAP:    state_n = RUN;
      HALT:    state_n = HALT;
      default: state_n = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BOOT;
      pc         <= RESET_VEC;
      bad_target <= '0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      bad_target <= bad_n;
    end
  end

  assign pc_plus4    = pc + 32'd4;
  assign fetch_valid = (state == RUN);
  assign trap        = (state == TRAP);
  assign retire_en   = (state == RUN) && !stall && !halt;
  assign taken_en    = retire_en && (sel != SEQ) && !mis;

`ifdef PC_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt  <= '0;
      retire_cnt <= '0;
    end else begin
      if (retire_en) retire_cnt <= retire_cnt + 32'd1;
      if (taken_en)  taken_cnt  <= taken_cnt + 32'd1;
    end
  end
`else
  logic unused_cnt;
  assign unused_cnt = taken_en;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with an expected-value queue.
// Counter checks are active when PC_PERF_CNT_EN is defined.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_src = 1'b0, jump = 1'b0, jalr = 1'b0;
  logic        stall = 1'b0, halt = 1'b0;
  logic [31:0] imm = '0, rs1_val = '0;
  logic [31:0] pc, pc_plus4, bad_target;
  logic        fetch_valid, trap;
`ifdef PC_PERF_CNT_EN
  logic [31:0] taken_cnt, retire_cnt;
`endif

  typedef struct {
    logic [31:0] pc;
    logic        fv;
    logic        tr;
    logic [31:0] bad;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          passed = 0;
  logic        prev_fv = 1'b0;
  logic [31:0] m_ret = '0, m_tak = '0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_src      (pc_src),
    .jump        (jump),
    .jalr        (jalr),
    .imm         (imm),
    .rs1_val     (rs1_val),
    .stall       (stall),
    .halt        (halt),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .fetch_valid (fetch_valid),
    .trap        (trap),
    .bad_target  (bad_target)
`ifdef PC_PERF_CNT_EN
    ,
    .taken_cnt   (taken_cnt),
    .retire_cnt  (retire_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic compare();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      $error("FAIL scoreboard: got empty queue expected entry");
      return;
    end
    e = sb.pop_front();
    chk("pc", pc, e.pc);
    chk("pc_plus4", pc_plus4, e.pc + 32'd4);
    chk("fetch_valid", {31'b0, fetch_valid}, {31'b0, e.fv});
    chk("trap", {31'b0, trap}, {31'b0, e.tr});
    chk("bad_target", bad_target, e.bad);
`ifdef PC_PERF_CNT_EN
    chk("retire_cnt", retire_cnt, m_ret);
    chk("taken_cnt", taken_cnt, m_tak);
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    {pc_src, jump, jalr, stall, halt} = '0;
    imm = '0;
    rs1_val = '0;
    m_ret = '0;
    m_tak = '0;
    prev_fv = 1'b0;
    sb.push_back(exp_t'{32'h0, 1'b0, 1'b0, 32'h0});
    #1 compare();
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(exp_t'{32'h0, 1'b0, 1'b0, 32'h0});
    #1 compare();
  endtask

  task automatic cyc(input logic ps, input logic j, input logic jr,
                     input logic st, input logic h,
                     input logic [31:0] im, input logic [31:0] rs,
                     input logic [31:0] epc, input logic efv,
                     input logic etr, input logic [31:0] ebad);
    pc_src = ps; jump = j; jalr = jr;
    stall = st; halt = h;
    imm = im; rs1_val = rs;
    if (prev_fv && !st && !h) begin
      m_ret++;
      if ((ps | j | jr) && !etr) m_tak++;
    end
    prev_fv = efv;
    sb.push_back(exp_t'{epc, efv, etr, ebad});
    @(posedge clk);
    #1 compare();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    cyc(0,0,0,0,0, 32'h0,  32'h0, 32'h0,  1,0,32'h0);
    cyc(0,0,0,0,0, 32'h0,  32'h0, 32'h4,  1,0,32'h0);
    cyc(0,0,0,0,0, 32'h0,  32'h0, 32'h8,  1,0,32'h0);
    cyc(0,0,0,0,0, 32'h0,  32'h0, 32'hC,  1,0,32'h0);
    cyc(0,1,0,0,0, 32'h14, 32'h0, 32'h20, 1,0,32'h0);
    cyc(1,0,0,1,0, 32'h40, 32'h0, 32'h20, 1,0,32'h0);
    cyc(1,0,0,0,0, 32'h40, 32'h0, 32'h60, 1,0,32'h0);
    cyc(1,1,1,0,0, 32'h4,  32'h1001, 32'h1004, 1,0,32'h0);
    cyc(0,0,1,0,0, 32'h0,  32'h10, 32'h10, 1,0,32'h0);
    cyc(0,1,0,0,0, 32'h6,  32'h0, 32'h100, 0,1,32'h16);
    cyc(0,1,0,0,0, 32'h8,  32'h0, 32'h100, 1,0,32'h16);
    cyc(0,0,0,0,0, 32'h0,  32'h0, 32'h104, 1,0,32'h16);
    cyc(0,0,0,0,0, 32'h0,  32'h0, 32'h108, 1,0,32'h16);
    cyc(0,0,1,0,0, 32'h1,  32'h201, 32'h100, 0,1,32'h202);
    cyc(0,0,0,0,0, 32'h0,  32'h0, 32'h100, 1,0,32'h202);
    cyc(0,0,1,0,0, 32'h0,  32'hFFFF_FFFC, 32'hFFFF_FFFC, 1,0,32'h202);
    cyc(0,0,0,0,0, 32'h0,  32'h0, 32'h0,  1,0,32'h202);
    cyc(0,0,0,0,0, 32'h0,  32'h0, 32'h4,  1,0,32'h202);
    cyc(1,0,0,0,0, 32'hFFFF_FFFC, 32'h0, 32'h0, 1,0,32'h202);
    cyc(0,1,0,0,0, 32'h30, 32'h0, 32'h30, 1,0,32'h202);
    cyc(0,1,0,1,0, 32'h8,  32'h0, 32'h30, 1,0,32'h202);
    cyc(1,0,0,0,1, 32'h40, 32'h0, 32'h30, 0,0,32'h202);
    cyc(0,1,1,0,0, 32'h40, 32'h8, 32'h30, 0,0,32'h202);
    cyc(0,0,0,0,0, 32'h0,  32'h0, 32'h30, 0,0,32'h202);
    cyc(0,0,0,0,1, 32'h0,  32'h0, 32'h30, 0,0,32'h202);
    #2;
    do_reset();
    cyc(0,0,0,0,0, 32'h0,  32'h0, 32'h0,  1,0,32'h0);
    cyc(0,0,0,0,0, 32'h0,  32'h0, 32'h4,  1,0,32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
